// File: rtl/oled_frame_streamer.sv
// SSD1306 frame streamer: panel reset, fixed init sequence, then page-major
// 1024-byte frames pulled from the screen bridge and shifted out on SPI mode 0.
module oled_frame_streamer #(
  parameter int unsigned CLK_DIV      = 2,
  parameter logic [15:0] RESET_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  output logic       read,
  output logic [5:0] row_idx,
  output logic [6:0] column_idx,
  input  logic [7:0] data,
  input  logic       ack,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_cs_n,
  output logic       oled_dc,
  output logic       oled_rst_n,
  output logic       busy,
  output logic       frame_done
);
  localparam int unsigned      DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       INIT_LAST = 5'd24;
  localparam logic [4:0]       HDR_LAST  = 5'd5;
  localparam logic [15:0]      RST_LAST  = RESET_CYCLES - 16'd1;

  typedef enum logic [2:0] {
    RST_LOW, RST_WAIT, INIT, IDLE, ADDR, FETCH, SEND, CLOSE
  } state_t;

  state_t           state;
  logic [15:0]      rst_cnt;
  logic [4:0]       cmd_idx;
  logic [2:0]       page;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [6:0]       shift;
  logic             lead;
  logic             pending;
  logic             close_frame;

  logic             half_end_c;
  logic             byte_end_c;
  logic [4:0]       cmd_sel_c;
  logic [7:0]       cmd_byte_c;

  function automatic logic [7:0] init_byte(input logic [4:0] i);
    case (i)
      5'd0:    init_byte = 8'hAE;
      5'd1:    init_byte = 8'hD5;
      5'd2:    init_byte = 8'h80;
      5'd3:    init_byte = 8'hA8;
      5'd4:    init_byte = 8'h3F;
      5'd5:    init_byte = 8'hD3;
      5'd6:    init_byte = 8'h00;
      5'd7:    init_byte = 8'h40;
      5'd8:    init_byte = 8'h8D;
      5'd9:    init_byte = 8'h14;
      5'd10:   init_byte = 8'h20;
      5'd11:   init_byte = 8'h00;
      5'd12:   init_byte = 8'hA1;
      5'd13:   init_byte = 8'hC8;
      5'd14:   init_byte = 8'hDA;
      5'd15:   init_byte = 8'h12;
      5'd16:   init_byte = 8'h81;
      5'd17:   init_byte = 8'hCF;
      5'd18:   init_byte = 8'hD9;
      5'd19:   init_byte = 8'hF1;
      5'd20:   init_byte = 8'hDB;
      5'd21:   init_byte = 8'h40;
      5'd22:   init_byte = 8'hA4;
      5'd23:   init_byte = 8'hA6;
      default: init_byte = 8'hAF;
    endcase
  endfunction

  // Horizontal addressing over the full 128x8-page window.
  function automatic logic [7:0] hdr_byte(input logic [4:0] i);
    case (i)
      5'd0:    hdr_byte = 8'h21;
      5'd1:    hdr_byte = 8'h00;
      5'd2:    hdr_byte = 8'h7F;
      5'd3:    hdr_byte = 8'h22;
      5'd4:    hdr_byte = 8'h00;
      default: hdr_byte = 8'h07;
    endcase
  endfunction

  always_comb begin
    half_end_c = (div_cnt == DIV_LAST);
    byte_end_c = half_end_c && oled_sclk && (bit_cnt == 3'd7);
    cmd_sel_c  = lead ? cmd_idx : cmd_idx + 5'd1;
    cmd_byte_c = (state == INIT) ? init_byte(cmd_sel_c) : hdr_byte(cmd_sel_c);
  end

  assign row_idx = {3'b000, page};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST_LOW;
      rst_cnt     <= '0;
      cmd_idx     <= '0;
      page        <= '0;
      column_idx  <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      shift       <= '0;
      lead        <= 1'b0;
      pending     <= 1'b0;
      close_frame <= 1'b0;
      read        <= 1'b0;
      oled_sclk   <= 1'b0;
      oled_mosi   <= 1'b0;
      oled_cs_n   <= 1'b1;
      oled_dc     <= 1'b0;
      oled_rst_n  <= 1'b0;
      busy        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      read       <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start && state != IDLE) pending <= 1'b1;

      unique case (state)
        RST_LOW: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt    <= '0;
            oled_rst_n <= 1'b1;
            state      <= RST_WAIT;
          end else begin
            rst_cnt <= rst_cnt + 16'd1;
          end
        end

        RST_WAIT: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt   <= '0;
            cmd_idx   <= '0;
            lead      <= 1'b1;
            oled_cs_n <= 1'b0;
            state     <= INIT;
          end else begin
            rst_cnt <= rst_cnt + 16'd1;
          end
        end

        IDLE: begin
          if (pending || frame_start) begin
            pending    <= 1'b0;
            cmd_idx    <= '0;
            page       <= '0;
            column_idx <= '0;
            lead       <= 1'b1;
            oled_cs_n  <= 1'b0;
            busy       <= 1'b1;
            state      <= ADDR;
          end
        end

        // Shared bit engine: lead cycle loads the first command byte after cs_n falls.
        INIT, ADDR, SEND: begin
          if (lead) begin
            lead      <= 1'b0;
            shift     <= cmd_byte_c[6:0];
            oled_mosi <= cmd_byte_c[7];
            oled_dc   <= 1'b0;
            oled_sclk <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
          end else if (!half_end_c) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else if (!oled_sclk) begin
            div_cnt   <= '0;
            oled_sclk <= 1'b1;
          end else if (!byte_end_c) begin
            div_cnt   <= '0;
            oled_sclk <= 1'b0;
            bit_cnt   <= bit_cnt + 3'd1;
            oled_mosi <= shift[6];
            shift     <= {shift[5:0], 1'b0};
          end else begin
            div_cnt   <= '0;
            oled_sclk <= 1'b0;
            bit_cnt   <= '0;
            if (state == SEND) begin
              column_idx <= column_idx + 7'd1;
              if (column_idx == 7'd127) page <= page + 3'd1;
              if (column_idx == 7'd127 && page == 3'd7) begin
                close_frame <= 1'b1;
                state       <= CLOSE;
              end else begin
                read  <= 1'b1;
                state <= FETCH;
              end
            end else if (cmd_idx == ((state == INIT) ? INIT_LAST : HDR_LAST)) begin
              if (state == INIT) begin
                close_frame <= 1'b0;
                state       <= CLOSE;
              end else begin
                read  <= 1'b1;
                state <= FETCH;
              end
            end else begin
              cmd_idx   <= cmd_idx + 5'd1;
              shift     <= cmd_byte_c[6:0];
              oled_mosi <= cmd_byte_c[7];
            end
          end
        end

        // sclk stays low and mosi holds while waiting for the bridge.
        FETCH: begin
          if (ack) begin
            shift     <= data[6:0];
            oled_mosi <= data[7];
            oled_dc   <= 1'b1;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= SEND;
          end
        end

        CLOSE: begin
          oled_cs_n  <= 1'b1;
          frame_done <= close_frame;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: state <= RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer: bridge model with random data key, SPI decoder
// and directed sequence covering reset/init, frames, handshake, queuing, idle, abort.
module tb_oled_frame_streamer;
  localparam int unsigned CLK_DIV      = 1;
  localparam logic [15:0] RESET_CYCLES = 16'd8;
  localparam int unsigned FRAME_CYCLES = (6 + 1024) * 16 * CLK_DIV + 1024 * 2 + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       read;
  logic [5:0] row_idx;
  logic [6:0] column_idx;
  logic [7:0] data = 8'h00;
  logic       ack = 1'b0;
  logic       oled_sclk, oled_mosi, oled_cs_n, oled_dc, oled_rst_n, busy, frame_done;

  oled_frame_streamer #(.CLK_DIV(CLK_DIV), .RESET_CYCLES(RESET_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .read(read),
    .row_idx(row_idx), .column_idx(column_idx), .data(data), .ack(ack),
    .oled_sclk(oled_sclk), .oled_mosi(oled_mosi), .oled_cs_n(oled_cs_n),
    .oled_dc(oled_dc), .oled_rst_n(oled_rst_n), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0] init_rom [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  logic [7:0] hdr_rom [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  // Bridge model: answers each read with {page, col[4:0]} ^ key, optionally late.
  logic [7:0] key = 8'h00;
  int         rd_count = 0;
  int         delay_at = -1;
  int         wait_left = 0;
  bit         outstanding = 1'b0;
  logic [7:0] resp = 8'h00;
  int         extra_reads = 0;
  int         sclk_viol = 0;

  always @(posedge clk) begin
    ack <= 1'b0;
    if (!rst_n) begin
      outstanding <= 1'b0;
    end else if (outstanding) begin
      if (read) extra_reads++;
      if (oled_sclk) sclk_viol++;
      if (wait_left == 0) begin
        ack         <= 1'b1;
        data        <= resp;
        outstanding <= 1'b0;
      end else begin
        wait_left <= wait_left - 1;
      end
    end else if (read) begin
      if (rd_count == delay_at) begin
        outstanding <= 1'b1;
        wait_left   <= 4;
        resp        <= {row_idx[2:0], column_idx[4:0]} ^ key;
      end else begin
        ack  <= 1'b1;
        data <= {row_idx[2:0], column_idx[4:0]} ^ key;
      end
      rd_count++;
    end
  end

  // SPI decoder and framing monitor, sampled on the falling clk edge.
  logic [8:0] q[$];
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;
  logic       prev_mosi = 1'b0;
  logic       prev_dc = 1'b0;
  logic [7:0] sh = 8'h00;
  int         nb = 0;
  int         fd_count = 0;
  int         fd_bad = 0;
  int         cs_low = 0;
  int         last_span = 0;
  int         spi_viol = 0;

  always @(negedge clk) begin
    if (oled_cs_n) begin
      nb = 0;
    end else begin
      if (oled_sclk && prev_sclk && (oled_mosi !== prev_mosi || oled_dc !== prev_dc))
        spi_viol++;
      if (oled_sclk && !prev_sclk) begin
        sh = {sh[6:0], oled_mosi};
        nb++;
        if (nb == 8) begin
          q.push_back({oled_dc, sh});
          nb = 0;
        end
      end
    end
    if (!oled_cs_n) cs_low++;
    else if (!prev_cs) begin
      last_span = cs_low;
      cs_low = 0;
    end
    if (frame_done) begin
      fd_count++;
      if (!(oled_cs_n && !prev_cs)) fd_bad++;
    end
    prev_sclk = oled_sclk;
    prev_cs   = oled_cs_n;
    prev_mosi = oled_mosi;
    prev_dc   = oled_dc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_reads(input string tag, input int n);
    int t = 0;
    while (rd_count < n && t < 20000) begin tick(); t++; end
    check(tag, 32'(rd_count >= n), 32'd1);
  endtask

  task automatic wait_frames(input string tag, input int n);
    int t = 0;
    while (fd_count < n && t < 40000) begin tick(); t++; end
    check(tag, 32'(fd_count), 32'(n));
  endtask

  task automatic run_reset_init(input string tag, input bit poke);
    int n;
    int bad;
    logic [8:0] e;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (oled_rst_n === 1'b0 && n < 100) begin tick(); n++; end
    check({tag, "_rst_low_cycles"}, 32'(n), 32'(RESET_CYCLES));
    n = 0;
    while (oled_cs_n === 1'b1 && n < 100) begin tick(); n++; end
    check({tag, "_rst_wait_cycles"}, 32'(n), 32'(RESET_CYCLES));
    if (poke) begin
      repeat (30) tick();
      pulse_start();
    end
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin tick(); n++; end
    check({tag, "_init_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_init_len"}, 32'(q.size()), 32'd25);
    bad = 0;
    for (int i = 0; i < 25 && q.size() > 0; i++) begin
      e = q.pop_front();
      if (e !== {1'b0, init_rom[i]}) bad++;
    end
    check({tag, "_init_bytes_bad"}, 32'(bad), 32'd0);
    tick();
    check({tag, "_autostart"}, 32'(busy), 32'(poke));
  endtask

  task automatic check_frame(input string tag, input logic [7:0] k);
    int bad = 0;
    logic [8:0] e;
    logic [7:0] exp_b;
    check({tag, "_len"}, 32'(q.size()), 32'd1030);
    if (q.size() >= 1030) begin
      for (int i = 0; i < 6; i++) begin
        e = q.pop_front();
        if (e !== {1'b0, hdr_rom[i]}) bad++;
      end
      for (int p = 0; p < 8; p++) begin
        for (int c = 0; c < 128; c++) begin
          exp_b = 8'(p * 32 + (c % 32)) ^ k;
          e = q.pop_front();
          if (e !== {1'b1, exp_b}) bad++;
        end
      end
    end
    check({tag, "_bytes_bad"}, 32'(bad), 32'd0);
    q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k1;
    logic [7:0] k2;
    int viol;

    k1 = 8'($urandom);
    key = k1;
    delay_at = 300;
    repeat (3) tick();
    check("rst_read", 32'(read), 32'd0);
    check("rst_row", 32'(row_idx), 32'd0);
    check("rst_col", 32'(column_idx), 32'd0);
    check("rst_sclk", 32'(oled_sclk), 32'd0);
    check("rst_mosi", 32'(oled_mosi), 32'd0);
    check("rst_cs_n", 32'(oled_cs_n), 32'd1);
    check("rst_dc", 32'(oled_dc), 32'd0);
    check("rst_oled_rst_n", 32'(oled_rst_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Reset and init, with a request queued during INIT.
    run_reset_init("init1", 1'b1);

    // Frame 1: random key, byte 300 acked 5 cycles late, 3 pulses mid-frame.
    wait_reads("f1_reach100", 100 + int'($urandom_range(0, 20)));
    pulse_start();
    wait_reads("f1_reach150", 150 + int'($urandom_range(0, 20)));
    pulse_start();
    wait_reads("f1_reach200", 200 + int'($urandom_range(0, 20)));
    pulse_start();
    wait_frames("f1_done", 1);
    rd_count = 0;
    k2 = 8'($urandom);
    key = k2;
    delay_at = -1;
    check_frame("frame1", k1);
    check("f1_span", 32'(last_span), 32'(FRAME_CYCLES + 5));
    check("f1_extra_reads", 32'(extra_reads), 32'd0);
    check("f1_sclk_in_fetch", 32'(sclk_viol), 32'd0);

    // Frame 2 is the single queued request; nominal bridge timing.
    wait_frames("f2_done", 2);
    check_frame("frame2", k2);
    check("f2_span", 32'(last_span), 32'(FRAME_CYCLES));
    check("fd_with_cs_rise", 32'(fd_bad), 32'd0);
    check("spi_stable_high", 32'(spi_viol), 32'd0);
    repeat (200) tick();
    check("no_third_frame_busy", 32'(busy), 32'd0);
    check("no_third_frame_count", 32'(fd_count), 32'd2);

    // Idle with no requests.
    viol = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (oled_cs_n !== 1'b1 || oled_sclk !== 1'b0 || read !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("idle_quiet", 32'(viol), 32'd0);

    // Mid-frame reset around data byte 500.
    rd_count = 0;
    pulse_start();
    wait_reads("f3_reach500", 500);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(oled_cs_n), 32'd1);
    check("abort_sclk", 32'(oled_sclk), 32'd0);
    check("abort_read", 32'(read), 32'd0);
    check("abort_oled_rst_n", 32'(oled_rst_n), 32'd0);
    repeat (3) tick();
    q.delete();
    run_reset_init("init2", 1'b0);
    check("abort_no_done", 32'(fd_count), 32'd2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
